// File: rtl/run_ctrl.sv
// run_ctrl: execution sequencer for the EnDMe core.
// Holds the core in reset while idle, primes it on start, gates each
// instruction through core_en (free-run or single-step), stops on halt or
// PC leaving the program, and faults when the watchdog count is reached.
//
// Handshake: core_en is a one-cycle strobe. Whenever it is high, the core
// executes exactly the instruction at instr_addr in that cycle. Every
// cycle with core_en high is counted in cycle_count. There is no
// backpressure from the core.
module run_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CYC_W  = 16,
  parameter logic [CYC_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              abort,
  input  logic              step_mode,
  input  logic              step,
  input  logic              halt,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic [ADDR_W-1:0] prog_len,
  output logic              core_reset,
  output logic              core_en,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             step_q;

  logic term;
  logic step_rise;
  logic want;
  logic at_limit;

  // Run-stop and step-request decode, shared by core_en and next-state.
  always_comb begin
    term      = halt | (instr_addr >= prog_len);
    step_rise = step & ~step_q;
    want      = step_mode ? step_rise : 1'b1;
    at_limit  = (cnt_q == TIMEOUT);
  end

  // Mealy instruction gate: a terminating instruction is never executed.
  assign core_en = (state_q == S_RUN) & want & ~term & ~at_limit;

  // Next-state and instruction counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) state_d = S_PRIME;
      end
      S_PRIME: begin
        if (abort) state_d = S_IDLE;
        else       state_d = S_RUN;
      end
      S_RUN: begin
        if (core_en) cnt_d = cnt_q + CYC_W'(1);
        if (abort)                 state_d = S_IDLE;
        else if (term)             state_d = S_DONE;
        else if (want && at_limit) state_d = S_FAULT;
      end
      S_DONE, S_FAULT: begin
        if (abort)      state_d = S_IDLE;
        else if (start) state_d = S_PRIME;
      end
      default: state_d = S_IDLE;
    endcase
    // Every new run starts counting from zero, visible already in PRIME.
    if (state_d == S_PRIME) cnt_d = '0;
  end

  // State, counter and step-edge registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step;
    end
  end

  // Status outputs decoded from registered state only.
  assign core_reset  = (state_q == S_IDLE) | (state_q == S_PRIME);
  assign busy        = (state_q == S_PRIME) | (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign timeout     = (state_q == S_FAULT);
  assign cycle_count = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized and directed bench for run_ctrl with a
// cycle-level reference model and an expected-response queue.
module tb_run_ctrl;
  localparam int AW = 16;
  localparam int CW = 16;
  localparam logic [CW-1:0] TO = 16'd12;

  localparam int P_IDLE  = 0;
  localparam int P_PRIME = 1;
  localparam int P_RUN   = 2;
  localparam int P_DONE  = 3;
  localparam int P_FAULT = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic          start, abort, step_mode, step, halt;
  logic [AW-1:0] instr_addr, prog_len;
  logic          core_reset, core_en, busy, done, timeout;
  logic [CW-1:0] cycle_count;
  logic [2:0]    dbg_state;

  run_ctrl #(.ADDR_W(AW), .CYC_W(CW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
    .step_mode(step_mode), .step(step), .halt(halt),
    .instr_addr(instr_addr), .prog_len(prog_len),
    .core_reset(core_reset), .core_en(core_en), .busy(busy),
    .done(done), .timeout(timeout), .cycle_count(cycle_count),
    .dbg_state_o(dbg_state)
  );

  // ---------------- reference model / core environment ----------------
  int            m_phase;
  logic [CW-1:0] m_cnt;
  logic [AW-1:0] m_pc;
  logic          m_step_prev;
  logic          halt_en;
  logic [AW-1:0] halt_pc;
  logic          halt_to;
  logic [AW-1:0] loop_len;

  function automatic logic model_halt();
    return (halt_en && (m_pc == halt_pc)) || (halt_to && (m_cnt == TO));
  endfunction

  assign instr_addr = m_pc;
  assign halt       = model_halt();

  // ---------------- scoreboard ----------------
  logic [20:0] exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string cur = "reset";

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    logic [20:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {core_reset, core_en, busy, done, timeout, cycle_count};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s cycle: got rst=%b en=%b busy=%b done=%b to=%b cnt=%0d expected rst=%b en=%b busy=%b done=%b to=%b cnt=%0d",
                 cur, a[20], a[19], a[18], a[17], a[16], a[15:0],
                 e[20], e[19], e[18], e[17], e[16], e[15:0]);
      end
    end
  end

  // ---------------- driver ----------------
  // One clock cycle: predict this cycle's outputs from the rules, queue
  // them, then advance the model after the edge.
  task automatic tick();
    logic term, rise, want, en;
    logic [20:0] exp_v;
    int            nph;
    logic [CW-1:0] ncnt;
    logic [AW-1:0] npc;
    term = model_halt() || (m_pc >= prog_len);
    rise = step && !m_step_prev;
    want = step_mode ? rise : 1'b1;
    en   = (m_phase == P_RUN) && want && !term && (m_cnt != TO);
    exp_v = {(m_phase == P_IDLE || m_phase == P_PRIME), en,
             (m_phase == P_PRIME || m_phase == P_RUN),
             (m_phase == P_DONE), (m_phase == P_FAULT), m_cnt};
    exp_q.push_back(exp_v);
    nph  = m_phase;
    ncnt = en ? m_cnt + 16'd1 : m_cnt;
    if (m_phase == P_IDLE || m_phase == P_PRIME) npc = '0;
    else if (en) npc = (loop_len != 0 && m_pc + 16'd1 == loop_len) ? 16'd0 : m_pc + 16'd1;
    else npc = m_pc;
    if (m_phase == P_IDLE) begin
      if (start && !abort) nph = P_PRIME;
    end else if (m_phase == P_PRIME) begin
      nph = abort ? P_IDLE : P_RUN;
    end else if (m_phase == P_RUN) begin
      if (abort) nph = P_IDLE;
      else if (term) nph = P_DONE;
      else if (want && m_cnt == TO) nph = P_FAULT;
    end else begin
      if (abort) nph = P_IDLE;
      else if (start) nph = P_PRIME;
    end
    if (nph == P_PRIME) ncnt = '0;
    @(posedge CLK);
    #1;
    m_phase     = nph;
    m_cnt       = ncnt;
    m_pc        = npc;
    m_step_prev = step;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; step = 0; step_mode = 0;
    halt_en = 0; halt_to = 0; halt_pc = '0; loop_len = '0;
  endtask

  task automatic go_idle();
    idle_inputs();
    abort = 1; tick(); abort = 0; tick();
  endtask

  task automatic start_run();
    start = 1; tick(); start = 0;
  endtask

  task automatic run_until_stop(int budget);
    int k;
    k = 0;
    while ((m_phase == P_PRIME || m_phase == P_RUN) && k < budget) begin
      tick(); k++;
    end
    chk({cur, " stop_bound"}, (k < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    idle_inputs();
    prog_len = 16'd10;
    m_phase = P_IDLE; m_cnt = '0; m_pc = '0; m_step_prev = 0;
    RESET = 1;
    #3;
    chk("reset core_reset", core_reset, 1);
    chk("reset core_en", core_en, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset timeout", timeout, 0);
    chk("reset cycle_count", cycle_count, 0);
    @(posedge CLK); #1; @(posedge CLK); #1;
    RESET = 0;
    tick(); tick();

    // Free-run to PC = prog_len.
    cur = "freerun";
    prog_len = 16'd10;
    start_run();
    run_until_stop(40);
    tick(); tick();
    chk("freerun done", done, 1);
    chk("freerun cycle_count", cycle_count, 10);
    chk("freerun pc frozen", m_pc, 10);
    go_idle();

    // Halt decode at PC 4.
    cur = "halt";
    prog_len = 16'd20; halt_en = 1; halt_pc = 16'd4;
    start_run();
    run_until_stop(40);
    chk("halt done", done, 1);
    chk("halt cycle_count", cycle_count, 4);
    go_idle();

    // Single-step: three pulses, then step held high for five cycles.
    cur = "step";
    prog_len = 16'd20; step_mode = 1;
    start_run(); tick();
    for (int p = 0; p < 3; p++) begin
      step = 1; tick(); step = 0; tick(); tick();
    end
    step = 1;
    for (int h = 0; h < 5; h++) tick();
    step = 0; tick();
    chk("step cycle_count", cycle_count, 4);
    chk("step busy", busy, 1);
    go_idle();

    // Watchdog on a looping program, then re-prime.
    cur = "watchdog";
    prog_len = 16'd100; loop_len = 16'd5;
    start_run();
    run_until_stop(60);
    chk("watchdog timeout", timeout, 1);
    chk("watchdog cycle_count", cycle_count, 12);
    start_run();
    chk("reprime busy", busy, 1);
    chk("reprime cycle_count", cycle_count, 0);
    go_idle();

    // start and abort together in IDLE.
    cur = "start_abort";
    start = 1; abort = 1; tick(); start = 0; abort = 0; tick();
    chk("start_abort stays idle", busy, 0);

    // Halt coincident with the watchdog limit: DONE wins.
    cur = "halt_vs_to";
    prog_len = 16'd100; loop_len = 16'd5; halt_to = 1;
    start_run();
    run_until_stop(60);
    chk("halt_vs_to done", done, 1);
    chk("halt_vs_to timeout", timeout, 0);
    chk("halt_vs_to cycle_count", cycle_count, 12);
    go_idle();

    // Randomized mix of all control inputs.
    cur = "random";
    for (int i = 0; i < 500; i++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 29) == 0);
      step  = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 19) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 49) == 0) prog_len = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) begin
        halt_en = $urandom_range(0, 1);
        halt_pc = 16'($urandom_range(0, 15));
        loop_len = 16'($urandom_range(0, 8));
        halt_to = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    go_idle();

    // Asynchronous reset in the middle of a run.
    cur = "midreset";
    prog_len = 16'd50;
    start_run();
    for (int k = 0; k < 20 && m_cnt != 16'd5; k++) tick();
    chk("midreset reached count", m_cnt, 5);
    RESET = 1;
    #1;
    chk("midreset core_reset", core_reset, 1);
    chk("midreset core_en", core_en, 0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset timeout", timeout, 0);
    chk("midreset cycle_count", cycle_count, 0);
    idle_inputs();
    @(posedge CLK); #1;
    m_phase = P_IDLE; m_cnt = '0; m_pc = '0; m_step_prev = 0;
    RESET = 0;
    tick(); tick();

    @(negedge CLK); #1;
    chk("queue drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
